uart_4b5b_bridge: RTL

//  Parametrised successor to the fixed-rate 230400 receive/4B5B transmit bridge.

---
 rtl/uart_4b5b_bridge.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_4b5b_bridge.sv
// 8N1 receiver feeding a small FIFO, drained by a transmitter that resends each
// byte as a 12-bit 4B5B frame or a 10-bit raw 8N1 frame. Errors are sticky flags.
module uart_4b5b_bridge #(
    parameter int RX_DIV  = 217,
    parameter int TX_DIV  = 181,
    parameter int FIFO_AW = 3
) (
    input  logic             CLK_50M,
    input  logic             RST_N,
    input  logic             RS232_DCE_RXD,
    output logic             RS232_DTE_TXD,
    input  logic             ENC_EN,
    input  logic             CLR_ERR,
    output logic [7:0]       LED,
    output logic             OVR,
    output logic             FERR,
    output logic             BUSY,
    output logic [FIFO_AW:0] FIFO_LEVEL
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam logic [15:0]        RX_HALF    = 16'(RX_DIV / 2);
    localparam logic [15:0]        RX_LAST    = 16'(RX_DIV - 1);
    localparam logic [15:0]        TX_LAST    = 16'(TX_DIV - 1);
    localparam logic [FIFO_AW:0]   FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} tx_state_t;

    function automatic logic [4:0] code_4b5b(input logic [3:0] nib);
        logic [4:0] c;
        case (nib)
            4'h0:    c = 5'b11110;
            4'h1:    c = 5'b01001;
            4'h2:    c = 5'b10100;
            4'h3:    c = 5'b10101;
            4'h4:    c = 5'b01010;
            4'h5:    c = 5'b01011;
            4'h6:    c = 5'b01110;
            4'h7:    c = 5'b01111;
            4'h8:    c = 5'b10010;
            4'h9:    c = 5'b10011;
            4'hA:    c = 5'b10110;
            4'hB:    c = 5'b10111;
            4'hC:    c = 5'b11010;
            4'hD:    c = 5'b11011;
            4'hE:    c = 5'b11100;
            default: c = 5'b11101;
        endcase
        return c;
    endfunction

    // Receive side: synchroniser, edge detect and RX FSM

    logic rxd_meta_q;
    logic rxd_sync_q;
    logic rxd_prev_q;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RS232_DCE_RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic [7:0]  led_q;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            led_q      <= 8'd0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rxd_prev_q && !rxd_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= RX_HALF;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == 16'd0) begin
                        if (rxd_sync_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= RX_LAST;
                            rx_bit_q   <= 3'd0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= RX_LAST;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_state_q <= RX_IDLE;
                        if (rxd_sync_q) begin
                            led_q <= rx_shift_q;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    logic rx_stop_tick;
    logic rx_push;
    logic rx_ferr_evt;

    always_comb begin
        rx_stop_tick = (rx_state_q == RX_STOP) && (rx_cnt_q == 16'd0);
        rx_push      = rx_stop_tick && rxd_sync_q;
        rx_ferr_evt  = rx_stop_tick && !rxd_sync_q;
    end

    // FIFO: a pop frees the slot the same cycle, so a push into a full FIFO
    // alongside a pop is still accepted.

    tx_state_t          tx_state_q;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic [FIFO_AW:0]   level_d;
    logic               fifo_pop;
    logic               fifo_push;
    logic               ovr_evt;
    logic [7:0]         fifo_rdata;

    always_comb begin
        fifo_pop   = (tx_state_q == TX_LOAD) && (level_q != '0);
        fifo_push  = rx_push && ((level_q != FULL_LEVEL) || fifo_pop);
        ovr_evt    = rx_push && !fifo_push;
        fifo_rdata = mem_q[rd_ptr_q];
        level_d    = level_q;
        if (fifo_push && !fifo_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!fifo_push && fifo_pop) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= rx_shift_q;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q <= level_d;
        end
    end

    // Sticky error flags; a new error event outranks a clear in the same cycle
    logic ovr_q;
    logic ferr_q;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (ovr_evt) begin
                ovr_q <= 1'b1;
            end else if (CLR_ERR) begin
                ovr_q <= 1'b0;
            end
            if (rx_ferr_evt) begin
                ferr_q <= 1'b1;
            end else if (CLR_ERR) begin
                ferr_q <= 1'b0;
            end
        end
    end

    // Transmit side: frame is stored in send order, bit 0 first
    logic [11:0] tx_frame_d;
    logic [3:0]  tx_last_d;

    always_comb begin
        tx_frame_d = {3'b111, fifo_rdata, 1'b0};
        tx_last_d  = 4'd9;
        if (ENC_EN) begin
            tx_frame_d = {1'b1, code_4b5b(fifo_rdata[7:4]), code_4b5b(fifo_rdata[3:0]), 1'b0};
            tx_last_d  = 4'd11;
        end
    end

    logic [11:0] tx_frame_q;
    logic [3:0]  tx_last_q;
    logic [3:0]  tx_bit_q;
    logic [15:0] tx_cnt_q;
    logic        txd_q;
    logic        busy_q;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            tx_state_q <= TX_IDLE;
            tx_frame_q <= 12'hFFF;
            tx_last_q  <= 4'd0;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= 16'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (level_q != '0) begin
                        tx_state_q <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    tx_frame_q <= tx_frame_d;
                    tx_last_q  <= tx_last_d;
                    tx_bit_q   <= 4'd0;
                    tx_cnt_q   <= TX_LAST;
                    txd_q      <= tx_frame_d[0];
                    busy_q     <= 1'b1;
                    tx_state_q <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (tx_cnt_q == 16'd0) begin
                        if (tx_bit_q == tx_last_q) begin
                            txd_q      <= 1'b1;
                            busy_q     <= 1'b0;
                            // Reload straight away so queued bytes follow with no idle gap
                            tx_state_q <= (level_q != '0) ? TX_LOAD : TX_IDLE;
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                            txd_q    <= tx_frame_q[tx_bit_q + 4'd1];
                            tx_cnt_q <= TX_LAST;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign RS232_DTE_TXD = txd_q;
    assign LED           = led_q;
    assign OVR           = ovr_q;
    assign FERR          = ferr_q;
    assign BUSY          = busy_q;
    assign FIFO_LEVEL    = level_q;

endmodule
